// File: rtl/sum_it_up.sv
// sum_it_up: accumulates a zero-terminated operand stream after an active-low go,
// then holds the sum with done high until the next go.
module sum_it_up #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int MAX_TERMS   = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   go_l,
    input  logic [WIDTH-1:0]       inA,
    output logic [WIDTH-1:0]       Q,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);
    typedef enum logic [1:0] {IDLE = 2'd0, SUM = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       q_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   done_q, ovf_q;
    logic [WIDTH:0]         sum_d;

    always_comb begin
        sum_d   = {1'b0, q_q} + {1'b0, inA};
        count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (!go_l) begin
                        state_q <= SUM;
                        q_q     <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                SUM: begin
                    if (inA == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        q_q     <= sum_d[WIDTH-1:0];
                        ovf_q   <= ovf_q | sum_d[WIDTH];
                        count_q <= count_d;
                        // Term limit reached: finish on the same edge as the last add
                        if (count_d == COUNT_WIDTH'(MAX_TERMS)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule
